// File: rtl/cache_ctrl.sv
// cache_ctrl: sequencing controller for a direct-mapped, one-word-per-line,
// write-through / no-write-allocate data cache. Holds tag/valid state,
// stalls the CPU on misses and stores, runs the memory handshake and keeps
// saturating hit/miss counters.
module cache_ctrl #(
  parameter int INDEX_BITS = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_stall,
  output logic [INDEX_BITS-1:0] arr_idx,
  output logic                  arr_we,
  output logic [DATA_WIDTH-1:0] arr_wdata,
  input  logic [DATA_WIDTH-1:0] arr_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic [CNT_WIDTH-1:0]  hit_cnt,
  output logic [CNT_WIDTH-1:0]  miss_cnt
);

  localparam int TAG_W = ADDR_WIDTH - INDEX_BITS - 2;
  localparam int LINES = 2 ** INDEX_BITS;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(3));

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_THRU = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [TAG_W-1:0]      r_tag [LINES];
  logic [LINES-1:0]      r_valid;
  logic [DATA_WIDTH-1:0] r_resp;
  logic [CNT_WIDTH-1:0]  r_hit_cnt;
  logic [CNT_WIDTH-1:0]  r_miss_cnt;

  logic [INDEX_BITS-1:0] w_idx;
  logic [TAG_W-1:0]      w_tag;
  logic                  w_hit;
  logic                  w_hit_inc;
  logic                  w_miss_inc;
  logic                  w_fill;
  logic                  w_arr_we;

  assign w_idx = cpu_addr[INDEX_BITS+1:2];
  assign w_tag = cpu_addr[ADDR_WIDTH-1:INDEX_BITS+2];
  assign w_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

  assign arr_idx   = w_idx;
  assign mem_addr  = cpu_addr & ALIGN_MASK;
  assign mem_wdata = cpu_wdata;
  assign hit_cnt   = r_hit_cnt;
  assign miss_cnt  = r_miss_cnt;
  // An array write landing on a reset edge would corrupt a line whose valid
  // bit is being cleared, so the strobe is suppressed while reset is held.
  assign arr_we    = w_arr_we & rst_n;

  // Next-state, handshake outputs and counter/refill strobes.
  always_comb begin
    w_state_next = r_state;
    cpu_stall    = 1'b0;
    cpu_rdata    = arr_rdata;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    w_arr_we     = 1'b0;
    arr_wdata    = cpu_wdata;
    w_hit_inc    = 1'b0;
    w_miss_inc   = 1'b0;
    w_fill       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (cpu_req) begin
          if (cpu_we) begin
            cpu_stall    = 1'b1;
            w_hit_inc    = w_hit;
            w_miss_inc   = ~w_hit;
            w_state_next = WR_THRU;
          end else if (w_hit) begin
            w_hit_inc = 1'b1;
          end else begin
            cpu_stall    = 1'b1;
            w_miss_inc   = 1'b1;
            w_state_next = RD_MISS;
          end
        end
      end
      RD_MISS: begin
        mem_req   = 1'b1;
        cpu_stall = 1'b1;
        if (mem_ready) begin
          w_arr_we     = 1'b1;
          arr_wdata    = mem_rdata;
          w_fill       = 1'b1;
          w_state_next = RESP;
        end
      end
      WR_THRU: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        cpu_stall = 1'b1;
        if (mem_ready) begin
          w_arr_we     = w_hit;
          w_state_next = RESP;
        end
      end
      RESP: begin
        cpu_rdata    = r_resp;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State register, valid bits, refill response latch and saturating counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_valid    <= '0;
      r_resp     <= '0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_fill) begin
        r_valid[w_idx] <= 1'b1;
        r_resp         <= mem_rdata;
      end
      if (w_hit_inc && !(&r_hit_cnt))
        r_hit_cnt <= r_hit_cnt + 1'b1;
      if (w_miss_inc && !(&r_miss_cnt))
        r_miss_cnt <= r_miss_cnt + 1'b1;
    end
  end

  // Tag store: contents are don't-care until the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (rst_n && w_fill)
      r_tag[w_idx] <= w_tag;
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: directed-vector bench for cache_ctrl with a behavioural
// external data array and a latency-programmable memory responder.
module tb_cache_ctrl;

  localparam int IB = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;
  logic [IB-1:0] arr_idx;
  logic          arr_we;
  logic [DW-1:0] arr_wdata;
  logic [DW-1:0] arr_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic [CW-1:0] hit_cnt;
  logic [CW-1:0] miss_cnt;

  logic [DW-1:0] arr_mem [2**IB];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cache_ctrl #(
    .INDEX_BITS(IB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .arr_idx(arr_idx), .arr_we(arr_we), .arr_wdata(arr_wdata),
    .arr_rdata(arr_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  // External data array: asynchronous read, synchronous write.
  assign arr_rdata = arr_mem[arr_idx];
  always @(posedge clk) begin
    if (arr_we) arr_mem[arr_idx] <= arr_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One CPU access; memory answers in the lat-th cycle mem_req is seen.
  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input int lat, input logic [31:0] mdata,
                      output int stalls, output logic [31:0] rdata,
                      output int pulses, output int saw_mem_we,
                      output logic [31:0] saw_addr, output logic [31:0] saw_wdata);
    int n;
    int cyc;
    logic done;
    stalls = 0; pulses = 0; saw_mem_we = 0; saw_addr = '0; saw_wdata = '0;
    rdata = '0; n = 0; cyc = 0; done = 1'b0;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (mem_req) begin
        n++;
        saw_addr = mem_addr;
        saw_wdata = mem_wdata;
        if (mem_we) saw_mem_we = 1;
        if (n == lat) begin
          mem_ready = 1'b1;
          mem_rdata = mdata;
        end
      end
      #1;
      if (arr_we) pulses++;
      if (!cpu_stall) begin
        rdata = cpu_rdata;
        done = 1'b1;
      end else begin
        stalls++;
      end
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
      mem_rdata = '0;
    end
    if (!done) chk("timeout", 32'(cyc), 32'd0);
    cpu_req = 1'b0;
  endtask

  int st, pu, mw;
  logic [31:0] rd, ma, wd;

  initial begin
    for (int i = 0; i < 2**IB; i++) arr_mem[i] = '0;
    rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0;
    cpu_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_stall", 32'(cpu_stall), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_arr_we", 32'(arr_we), 32'd0);
    chk("rst_hit", 32'(hit_cnt), 32'd0);
    chk("rst_miss", 32'(miss_cnt), 32'd0);
    @(posedge clk); #1;

    // Cold load miss, L=3
    xact(1'b0, 32'h10, 32'h0, 3, 32'hDEAD_BEEF, st, rd, pu, mw, ma, wd);
    chk("ld1_stall", 32'(st), 32'd4);
    chk("ld1_data", rd, 32'hDEAD_BEEF);
    chk("ld1_arr_we", 32'(pu), 32'd1);
    chk("ld1_maddr", ma, 32'h10);
    chk("ld1_mem_we", 32'(mw), 32'd0);
    chk("ld1_miss", 32'(miss_cnt), 32'd1);
    // Immediate repeat hits
    xact(1'b0, 32'h10, 32'h0, 1, 32'h0, st, rd, pu, mw, ma, wd);
    chk("ld2_stall", 32'(st), 32'd0);
    chk("ld2_data", rd, 32'hDEAD_BEEF);
    chk("ld2_hit", 32'(hit_cnt), 32'd1);

    // Conflict at index 4
    xact(1'b0, 32'h30, 32'h0, 2, 32'h3030_3030, st, rd, pu, mw, ma, wd);
    chk("conf_stall", 32'(st), 32'd3);
    chk("conf_data", rd, 32'h3030_3030);
    xact(1'b0, 32'h10, 32'h0, 1, 32'hDEAD_BEEF, st, rd, pu, mw, ma, wd);
    chk("reld_stall", 32'(st), 32'd2);
    chk("reld_miss", 32'(miss_cnt), 32'd3);
    xact(1'b0, 32'h10, 32'h0, 1, 32'h0, st, rd, pu, mw, ma, wd);
    chk("tag4_hit_stall", 32'(st), 32'd0);
    chk("tag4_hit_cnt", 32'(hit_cnt), 32'd2);

    // Store hit (unaligned byte address, aligned on the memory side)
    xact(1'b1, 32'h13, 32'hA5A5_A5A5, 2, 32'h0, st, rd, pu, mw, ma, wd);
    chk("sth_stall", 32'(st), 32'd3);
    chk("sth_mem_we", 32'(mw), 32'd1);
    chk("sth_maddr", ma, 32'h10);
    chk("sth_mwdata", wd, 32'hA5A5_A5A5);
    chk("sth_arr_we", 32'(pu), 32'd1);
    chk("sth_hit", 32'(hit_cnt), 32'd3);
    xact(1'b0, 32'h10, 32'h0, 1, 32'h0, st, rd, pu, mw, ma, wd);
    chk("sth_ld_stall", 32'(st), 32'd0);
    chk("sth_ld_data", rd, 32'hA5A5_A5A5);

    // Store miss: no allocation
    xact(1'b1, 32'h44, 32'h1234_5678, 1, 32'h0, st, rd, pu, mw, ma, wd);
    chk("stm_stall", 32'(st), 32'd2);
    chk("stm_mem_we", 32'(mw), 32'd1);
    chk("stm_maddr", ma, 32'h44);
    chk("stm_arr_we", 32'(pu), 32'd0);
    chk("stm_miss", 32'(miss_cnt), 32'd4);
    xact(1'b0, 32'h44, 32'h0, 1, 32'h1234_5678, st, rd, pu, mw, ma, wd);
    chk("stm_ld_stall", 32'(st), 32'd2);
    chk("stm_ld_data", rd, 32'h1234_5678);
    chk("stm_ld_miss", 32'(miss_cnt), 32'd5);

    // Reset coinciding with mem_ready during RD_MISS
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h08;
    @(posedge clk); #1;            // IDLE accepted, now RD_MISS
    @(negedge clk);
    chk("rr_mem_req_on", 32'(mem_req), 32'd1);
    mem_ready = 1'b1; mem_rdata = 32'h0BAD_0BAD; rst_n = 1'b0;
    #1;
    chk("rr_arr_we", 32'(arr_we), 32'd0);
    @(posedge clk); #1;
    mem_ready = 1'b0; mem_rdata = '0; rst_n = 1'b1; cpu_req = 1'b0;
    @(negedge clk);
    chk("rr_mem_req_off", 32'(mem_req), 32'd0);
    chk("rr_arr_mem", arr_mem[2], 32'h0);
    chk("rr_miss_clr", 32'(miss_cnt), 32'd0);
    @(posedge clk); #1;
    xact(1'b0, 32'h08, 32'h0, 1, 32'h0808_0808, st, rd, pu, mw, ma, wd);
    chk("rr_ld_stall", 32'(st), 32'd2);
    chk("rr_ld_miss", 32'(miss_cnt), 32'd1);

    // Hit counter saturation (4-bit counter)
    for (int k = 0; k < 15; k++)
      xact(1'b0, 32'h08, 32'h0, 1, 32'h0, st, rd, pu, mw, ma, wd);
    chk("sat_hit15", 32'(hit_cnt), 32'hF);
    xact(1'b0, 32'h08, 32'h0, 1, 32'h0, st, rd, pu, mw, ma, wd);
    chk("sat_stall", 32'(st), 32'd0);
    chk("sat_data", rd, 32'h0808_0808);
    chk("sat_hit", 32'(hit_cnt), 32'hF);
    chk("sat_miss", 32'(miss_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
